// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit feeding the 16-bit instruction decoder.
//
// Owns the program counter, issues single-outstanding read requests to instruction
// memory, buffers returned words in a small FIFO and presents them to decode with a
// valid/ready handshake. Redirects restart fetch at a new address and squash any
// buffered or in-flight words.
//
// Optional feature macro: IFETCH_SKID_EN
//   defined   -> 2-entry buffer, a request may be issued while one word is held
//                (full-rate fetch with zero-wait memory).
//   undefined -> 1-entry buffer, a request is issued only when the buffer will be
//                empty (half-rate fetch with zero-wait memory).
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   o_memReq, o_memAddr          read request and its word address (held until ack)
//   i_memAck, i_memData          read completion and returned instruction word
//   o_instrValid, i_instrReady   decode handshake; pop = valid && ready
//   o_instrCode, o_instrPc       head instruction and its address
//   i_redirect, i_redirectAddr   taken jump/branch and its target address
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_memReq,
  output logic [ADDR_W-1:0]  o_memAddr,
  input  logic               i_memAck,
  input  logic [INSTR_W-1:0] i_memData,
  output logic               o_instrValid,
  input  logic               i_instrReady,
  output logic [INSTR_W-1:0] o_instrCode,
  output logic [ADDR_W-1:0]  o_instrPc,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirectAddr
);

`ifdef IFETCH_SKID_EN
  localparam int unsigned Depth = 2;
`else
  localparam int unsigned Depth = 1;
`endif
  localparam logic [1:0] DepthM1 = 2'(Depth - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StSquash} state_e;

  state_e             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;    // address of the current/next request
  logic [ADDR_W-1:0]  redir_q, redir_d;  // target held while a squashed request drains
  logic [1:0]         count_q, count_d;
  logic [INSTR_W-1:0] code_q [Depth];
  logic [INSTR_W-1:0] code_d [Depth];
  logic [ADDR_W-1:0]  pc_q   [Depth];
  logic [ADDR_W-1:0]  pc_d   [Depth];

  logic       pop;
  logic [1:0] cnt;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    redir_d = redir_q;
    count_d = count_q;
    code_d  = code_q;
    pc_d    = pc_q;
    pop     = (count_q != 2'd0) && i_instrReady;
    cnt     = count_q - {1'b0, pop};

    if (i_redirect) begin
      // Buffer is flushed; a pop this cycle has already been consumed by decode.
      count_d = 2'd0;
      if ((state_q == StReq || state_q == StSquash) && !i_memAck) begin
        // Request still in flight: keep its address on the bus until it drains.
        state_d = StSquash;
        redir_d = i_redirectAddr;
      end else begin
        state_d = StReq;
        addr_d  = i_redirectAddr;
      end
    end else begin
      if (pop) begin
`ifdef IFETCH_SKID_EN
        code_d[0] = code_q[1];
        pc_d[0]   = pc_q[1];
`endif
      end

      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (i_memAck) begin
`ifdef IFETCH_SKID_EN
            if (cnt == 2'd0) begin
              code_d[0] = i_memData;
              pc_d[0]   = addr_q;
            end else begin
              code_d[1] = i_memData;
              pc_d[1]   = addr_q;
            end
`else
            code_d[0] = i_memData;
            pc_d[0]   = addr_q;
`endif
            cnt    = cnt + 2'd1;
            addr_d = addr_q + 1'b1;
          end
          state_d = (cnt <= DepthM1) ? StReq : StWait;
        end
        StWait: state_d = (cnt <= DepthM1) ? StReq : StWait;
        StSquash: begin
          // Returning data belongs to the abandoned path and is dropped.
          if (i_memAck) begin
            state_d = StReq;
            addr_d  = redir_q;
          end
        end
        default: state_d = StIdle;
      endcase
      count_d = cnt;
    end

    mem_req_d = (state_d == StReq) || (state_d == StSquash);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      mem_req_q <= 1'b0;
      addr_q    <= RESET_PC;
      redir_q   <= RESET_PC;
      count_q   <= 2'd0;
      for (int i = 0; i < Depth; i++) begin
        code_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      addr_q    <= addr_d;
      redir_q   <= redir_d;
      count_q   <= count_d;
      code_q    <= code_d;
      pc_q      <= pc_d;
    end
  end

  assign o_memReq     = mem_req_q;
  assign o_memAddr    = addr_q;
  assign o_instrValid = (count_q != 2'd0);
  assign o_instrCode  = code_q[0];
  assign o_instrPc    = pc_q[0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. Memory model returns addr + 0x1000 after a
// programmable number of wait cycles, or can be driven by hand. Expected
// {code, pc} pairs are queued as stimulus is applied and compared on each pop.
module tb_instr_fetch;

`ifdef IFETCH_SKID_EN
  localparam int Depth = 2;
`else
  localparam int Depth = 1;
`endif

  typedef struct packed {
    logic [15:0] code;
    logic [15:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_memReq;
  logic [15:0] o_memAddr;
  logic        i_memAck;
  logic [15:0] i_memData;
  logic        o_instrValid;
  logic        i_instrReady = 1'b0;
  logic [15:0] o_instrCode;
  logic [15:0] o_instrPc;
  logic        i_redirect = 1'b0;
  logic [15:0] i_redirectAddr = 16'h0;

  logic        man_mode = 1'b0;
  logic        man_ack = 1'b0;
  logic [15:0] man_data = 16'h0;
  int          lat = 0;
  int          wait_cnt = 0;
  int          cyc = 0;
  int          ack_cnt = 0;

  ent_t exp_q[$];
  int   pop_cyc[$];
  int   n_chk = 0;
  int   n_pass = 0;

  instr_fetch #(
    .ADDR_W  (16),
    .INSTR_W (16),
    .RESET_PC(16'h0010)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .o_memReq      (o_memReq),
    .o_memAddr     (o_memAddr),
    .i_memAck      (i_memAck),
    .i_memData     (i_memData),
    .o_instrValid  (o_instrValid),
    .i_instrReady  (i_instrReady),
    .o_instrCode   (o_instrCode),
    .o_instrPc     (o_instrPc),
    .i_redirect    (i_redirect),
    .i_redirectAddr(i_redirectAddr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (o_memReq && i_memAck) ack_cnt <= ack_cnt + 1;

  // Memory wait counter: counts cycles the current request has been held.
  always @(posedge clk) begin
    if (i_rst || !o_memReq || i_memAck) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  assign i_memAck  = man_mode ? man_ack : (o_memReq && (wait_cnt == lat));
  assign i_memData = man_mode ? man_data : (o_memAddr + 16'h1000);

  // One clock cycle; the scoreboard samples the handshake on the falling edge.
  task automatic step();
    ent_t e;
    @(negedge clk);
    if (o_instrValid && i_instrReady) begin
      pop_cyc.push_back(cyc);
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_extra: got code %h pc %h, expected no transfer", o_instrCode,
                 o_instrPc);
      end else begin
        e = exp_q.pop_front();
        if ({o_instrCode, o_instrPc} !== e)
          $display("FAIL sb_word: got code %h pc %h, expected code %h pc %h", o_instrCode,
                   o_instrPc, e.code, e.pc);
        else n_pass++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    i_rst = 1'b1;
    i_instrReady = 1'b0;
    i_redirect = 1'b0;
    man_mode = 1'b0;
    man_ack = 1'b0;
    lat = l;
    exp_q.delete();
    repeat (3) step();
    i_rst = 1'b0;
  endtask

  task automatic push_seq(input logic [15:0] pc0, input int n);
    logic [15:0] p;
    p = pc0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{code: p + 16'h1000, pc: p});
      p = p + 16'h1;
    end
  endtask

  task automatic drain(input int budget, output bit ok);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    ok = (exp_q.size() == 0);
  endtask

  // Step until the buffer is full and no request is pending.
  task automatic wait_full(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!o_memReq && o_instrValid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bit got;
    i_rst = 1'b1;
    lat = 3;
    repeat (2) step();
    n_chk++; if (o_memReq !== 1'b0) $display("FAIL rst_req: got %b want 0", o_memReq);
    else n_pass++;
    n_chk++; if (o_instrValid !== 1'b0) $display("FAIL rst_valid: got %b want 0", o_instrValid);
    else n_pass++;
    n_chk++; if (o_instrCode !== 16'h0) $display("FAIL rst_code: got %h want 0000", o_instrCode);
    else n_pass++;
    n_chk++; if (o_instrPc !== 16'h0) $display("FAIL rst_pc: got %h want 0000", o_instrPc);
    else n_pass++;
    n_chk++; if (o_memAddr !== 16'h0010) $display("FAIL rst_addr: got %h want 0010", o_memAddr);
    else n_pass++;
    i_rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (o_memReq === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    n_chk++; if (!got || o_memAddr !== 16'h0010)
      $display("FAIL first_req: got req %b addr %h want req 1 addr 0010", got, o_memAddr);
    else n_pass++;
  endtask

  task automatic test_stream();
    bit ok;
    int n0;
    int gap;
    do_reset(0);
    i_instrReady = 1'b1;
    push_seq(16'h0010, 6);
    n0 = pop_cyc.size();
    drain(40, ok);
    i_instrReady = 1'b0;
    n_chk++; if (!ok) $display("FAIL stream_drain: %0d words left want 0", exp_q.size());
    else n_pass++;
    gap = (Depth == 2) ? 1 : 2;
    if (pop_cyc.size() >= n0 + 6) begin
      for (int k = 1; k < 6; k++) begin
        n_chk++;
        if (pop_cyc[n0+k] - pop_cyc[n0+k-1] != gap)
          $display("FAIL stream_rate: gap %0d cycles want %0d", pop_cyc[n0+k] - pop_cyc[n0+k-1],
                   gap);
        else n_pass++;
      end
    end else begin
      n_chk++;
      $display("FAIL stream_rate: %0d pops want 6", pop_cyc.size() - n0);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int a0;
    do_reset(0);
    a0 = ack_cnt;
    repeat (6) step();
    n_chk++; if (o_memReq !== 1'b0) $display("FAIL stall_req: got %b want 0", o_memReq);
    else n_pass++;
    n_chk++; if (o_instrValid !== 1'b1) $display("FAIL stall_valid: got %b want 1", o_instrValid);
    else n_pass++;
    n_chk++; if (ack_cnt - a0 != Depth)
      $display("FAIL stall_fill: got %0d words fetched want %0d", ack_cnt - a0, Depth);
    else n_pass++;
    push_seq(16'h0010, 6);
    i_instrReady = 1'b1;
    drain(40, ok);
    i_instrReady = 1'b0;
    n_chk++; if (!ok) $display("FAIL stall_drain: %0d words left want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_redirect_full();
    bit ok;
    do_reset(0);
    wait_full(10, ok);
    n_chk++; if (!ok) $display("FAIL rdf_fill: got not full want full");
    else n_pass++;
    i_redirect = 1'b1;
    i_redirectAddr = 16'h0200;
    step();
    i_redirect = 1'b0;
    n_chk++; if (o_instrValid !== 1'b0) $display("FAIL rdf_valid: got %b want 0", o_instrValid);
    else n_pass++;
    n_chk++; if (o_memReq !== 1'b1 || o_memAddr !== 16'h0200)
      $display("FAIL rdf_req: got req %b addr %h want req 1 addr 0200", o_memReq, o_memAddr);
    else n_pass++;
    push_seq(16'h0200, 4);
    i_instrReady = 1'b1;
    drain(40, ok);
    i_instrReady = 1'b0;
    n_chk++; if (!ok) $display("FAIL rdf_drain: %0d words left want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_redirect_pending();
    bit ok;
    do_reset(3);
    wait_full(40, ok);
    n_chk++; if (!ok) $display("FAIL rdp_fill: got not full want full");
    else n_pass++;
    i_redirect = 1'b1;
    i_redirectAddr = 16'h0005;
    step();
    n_chk++; if (o_memReq !== 1'b1 || o_memAddr !== 16'h0005)
      $display("FAIL rdp_req5: got req %b addr %h want req 1 addr 0005", o_memReq, o_memAddr);
    else n_pass++;
    i_redirectAddr = 16'h0300;
    step();
    i_redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (o_memReq !== 1'b1 || o_memAddr !== 16'h0005 || o_instrValid !== 1'b0)
        $display("FAIL rdp_hold: got req %b addr %h valid %b want 1 0005 0", o_memReq,
                 o_memAddr, o_instrValid);
      else n_pass++;
      step();
    end
    n_chk++; if (o_memReq !== 1'b1 || o_memAddr !== 16'h0300)
      $display("FAIL rdp_new: got req %b addr %h want req 1 addr 0300", o_memReq, o_memAddr);
    else n_pass++;
    push_seq(16'h0300, 2);
    i_instrReady = 1'b1;
    drain(40, ok);
    i_instrReady = 1'b0;
    n_chk++; if (!ok) $display("FAIL rdp_drain: %0d words left want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset(0);
    wait_full(10, ok);
    i_redirect = 1'b1;
    i_redirectAddr = 16'hffff;
    step();
    i_redirect = 1'b0;
    n_chk++; if (o_memAddr !== 16'hffff) $display("FAIL wrap_addr: got %h want ffff", o_memAddr);
    else n_pass++;
    push_seq(16'hffff, 3);
    i_instrReady = 1'b1;
    drain(40, ok);
    i_instrReady = 1'b0;
    n_chk++; if (!ok) $display("FAIL wrap_drain: %0d words left want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit got;
    do_reset(0);
    man_mode = 1'b1;
    man_ack = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (o_memReq === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    n_chk++; if (!got) $display("FAIL rm_req: got req 0 want 1");
    else n_pass++;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    man_ack = 1'b1;
    man_data = 16'hdead;
    n_chk++; if (o_memReq !== 1'b0 || o_instrValid !== 1'b0)
      $display("FAIL rm_abandon: got req %b valid %b want 0 0", o_memReq, o_instrValid);
    else n_pass++;
    step();
    man_ack = 1'b0;
    n_chk++; if (o_memReq !== 1'b1 || o_memAddr !== 16'h0010 || o_instrValid !== 1'b0)
      $display("FAIL rm_restart: got req %b addr %h valid %b want 1 0010 0", o_memReq,
               o_memAddr, o_instrValid);
    else n_pass++;
    man_mode = 1'b0;
    push_seq(16'h0010, 1);
    i_instrReady = 1'b1;
    drain(20, ok);
    i_instrReady = 1'b0;
    n_chk++; if (!ok) $display("FAIL rm_drain: %0d words left want 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_pending();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the producer side of the 16-bit instruction-code interface consumed by the `control` decoder. It owns the program counter and issues single-outstanding read requests to instruction memory. Fetched words are buffered and presented to decode with a valid/ready handshake. Jump and branch redirects from the execute path restart fetch at a new address and squash any in-flight or buffered words.

## Interface
- ADDR_W, 16, instruction-memory word-address width
- INSTR_W, 16, instruction width; matches the decoder's `i_instrCode`
- RESET_PC, 0, fetch address after reset
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  synchronous, active-high reset
- o_memReq  out  1  read request; once high, held with stable `o_memAddr` until acknowledged
- o_memAddr  out  ADDR_W  word address of the outstanding request (the current PC)
- i_memAck  in  1  read complete; `i_memData` valid this cycle; may coincide with the first cycle of `o_memReq`
- i_memData  in  INSTR_W  instruction word
- o_instrValid  out  1  `o_instrCode`/`o_instrPc` hold a valid instruction
- i_instrReady  in  1  decode accepts; transfer ("pop") = `o_instrValid && i_instrReady`
- o_instrCode  out  INSTR_W  head instruction, to decoder
- o_instrPc  out  ADDR_W  address of head instruction
- i_redirect  in  1  jump/branch taken this cycle
- i_redirectAddr  in  ADDR_W  new fetch address

## Operation
- Buffer: FIFO of depth 2 (depth 1 without IFETCH_SKID_EN). Each entry holds {code, pc}. The head drives `o_instrCode`/`o_instrPc`. `o_instrValid` = buffer non-empty.
- FSM states:
  - REQ: `o_memReq=1`.
  - WAIT: `o_memReq=0`, buffer too full to issue.
  - SQUASH: `o_memReq=1`, request still pending but its data will be discarded.
- REQ, on ack:
  - Push {i_memData, PC}; PC ← PC+1 (wraps modulo 2^ADDR_W).
  - Let count_next = count + push − pop.
  - Stay in REQ if count_next ≤ DEPTH−1, else go to WAIT.
- WAIT: go to REQ when count_next ≤ DEPTH−1 (i.e. on pop).
- Redirect (highest priority, any state):
  - A pop in the same cycle still counts as consumed.
  - All other buffered entries are flushed; count ← 0.
  - PC ← i_redirectAddr.
  - If a request is outstanding and not acked this cycle: go to SQUASH. `o_memAddr` stays at the old address until ack; that data is dropped; then go to REQ with the redirect address.
  - If acked the same cycle: the data is dropped; next state is REQ.
  - Otherwise: next state is REQ.
- SQUASH: a further redirect updates the target PC (latest wins) and stays in SQUASH. On ack, data is dropped and the FSM goes to REQ.
- Reset values:
  - `o_memReq`=0, `o_instrValid`=0, `o_instrCode`=0, `o_instrPc`=0.
  - `o_memAddr`=RESET_PC; count=0; state=WAIT-equivalent idle for one cycle, then REQ.
- `o_instrCode`/`o_instrPc` are don't-care while `o_instrValid`=0.

## Timing
- First request: `o_memReq`=1 in the first cycle after `i_rst` deasserts, with `o_memAddr`=RESET_PC.
- Latency: ack sampled at edge t → `o_instrValid`=1 with that word in cycle t+1.
- Throughput, zero-wait memory (ack same cycle as req) and `i_instrReady`=1:
  - With skid: 1 instruction/cycle.
  - Without skid: 1 per 2 cycles.
- Redirect at edge t: `o_instrValid`=0 in cycle t+1.
  - If no request is pending: `o_memAddr`=i_redirectAddr with `o_memReq`=1 in cycle t+1.
  - If a request is pending: the new address appears the cycle after the pending ack.
- `i_rst` mid-request: the request is abandoned; a late `i_memAck` while `o_memReq`=0 is ignored.
- Push and pop in the same cycle with a full buffer: allowed; count unchanged.

## Configuration
- IFETCH_SKID_EN defined: DEPTH=2.
  - A request may be issued while one entry is held.
  - Full-rate fetch.
- IFETCH_SKID_EN undefined: DEPTH=1.
  - A request is issued only when the buffer will be empty.
  - Half-rate fetch with zero-wait memory.
- The interface is identical in both builds.

## Test plan
- Reset release, RESET_PC=0x0010, zero-wait memory returning addr+0x1000, ready=1 → `o_instrCode` sequence 0x1010, 0x1011, 0x1012 on consecutive cycles (skid build) or every other cycle (no-skid build), with `o_instrPc` 0x0010, 0x0011, 0x0012.
- Hold `i_instrReady`=0 for 5 cycles → `o_memReq` drops after the buffer fills (2 words, or 1 without skid); no word is lost or duplicated when ready returns.
- Redirect to 0x0200 while the buffer holds 2 words and no request is pending → next valid is 0x1200 with `o_instrPc`=0x0200; the flushed words never appear.
- Memory with 3-cycle ack latency, redirect to 0x0300 one cycle after a request to 0x0005 → `o_memAddr` stays 0x0005 until ack; that data is dropped; the next request is 0x0300.
- PC=0xFFFF fetched → the next request is 0x0000.
- Assert `i_rst` during a pending request, ack arrives one cycle later → no valid output; the first request after release is RESET_PC.
